// File: rtl/rx_word_pkg.sv
// Shared UART constants and receiver state encodings for the rx_word receive path.
// Clock and baud definitions live here so every UART block derives its bit timing the same way.
package rx_word_pkg;

    localparam int CLK12_HZ = 12_000_000;
    localparam int B9600    = 9600;
    localparam int B115200  = 115200;

    // 12 MHz / 115200 truncates to 104 clocks per bit.
    localparam int UART_CLKS_PER_BIT     = CLK12_HZ / B115200;
    localparam int UART_NUM_BYTES        = 4;
    localparam int UART_WORD_TIMEOUT     = 20 * UART_CLKS_PER_BIT;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_word_if.sv
// Word handshake between the UART word assembler (master) and its consumer (slave).
// word_valid rises with a new word and stays high, with word stable, until the consumer
// raises word_ack while word_valid is high; word_ack with word_valid low is ignored.
interface rx_word_if #(
    parameter int NUM_BYTES = 4
);

    logic [8*NUM_BYTES-1:0] word;
    logic                   word_valid;
    logic                   word_ack;

    modport master (
        output word,
        output word_valid,
        input  word_ack
    );

    modport slave (
        input  word,
        input  word_valid,
        output word_ack
    );

endinterface

// File: rtl/rx_word_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte/error pulses.
// A start bit that is high again at its midpoint is treated as a glitch and ignored.
module uart_rx_byte
    import rx_word_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk12,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       byte_err,
    output rx_state_e  state
);

    localparam int               CNT_W     = idx_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_sync;
    logic             w_rx;
    rx_state_e        r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_err;

    assign w_rx = r_sync[1];

    always_ff @(posedge clk12) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_state   <= RX_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx) begin
                        r_state   <= RX_START;
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    // Counting restarts at the start-bit midpoint, so each sample lands mid-bit.
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= RX_IDLE;
                        if (w_rx) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign data       = r_data;
    assign byte_valid = r_valid;
    assign byte_err   = r_err;
    assign state      = r_state;

endmodule

// File: rtl/rx_word.sv
// UART word receiver: assembles NUM_BYTES received bytes (first byte in word[7:0]) into a word
// offered over a valid/ack handshake; partial words are dropped on framing error or idle timeout.
module rx_word
    import rx_word_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int NUM_BYTES    = UART_NUM_BYTES,
    parameter int TIMEOUT_CLKS = UART_WORD_TIMEOUT
) (
    input  logic        clk12,
    input  logic        rst,
    input  logic        rx,
    rx_word_if.master   wif,
    output logic        frame_err,
    output logic        overrun,
    output logic        led,
    output rx_state_e   rx_state
);

    localparam int                W       = 8 * NUM_BYTES;
    localparam int                BIDX_W  = idx_width(NUM_BYTES);
    localparam int                TO_W    = idx_width(TIMEOUT_CLKS);
    localparam logic [BIDX_W-1:0] LAST_IX = BIDX_W'(NUM_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic [7:0]        w_byte;
    logic              w_byte_valid;
    logic              w_byte_err;
    logic [W-1:0]      w_merged;
    logic              w_word_done;

    logic [BIDX_W-1:0] r_byte_index;
    logic [TO_W-1:0]   r_timeout;
    logic [W-1:0]      r_word_buf;
    logic              r_frame_err;
    logic [W-1:0]      r_word;
    logic              r_word_valid;
    logic              r_overrun;
    logic              r_led;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk12      (clk12),
        .rst        (rst),
        .rx         (rx),
        .data       (w_byte),
        .byte_valid (w_byte_valid),
        .byte_err   (w_byte_err),
        .state      (rx_state)
    );

    // The final byte is merged combinationally so the word can be presented one cycle later.
    always_comb begin
        w_merged = r_word_buf;
        w_merged[{r_byte_index, 3'b000} +: 8] = w_byte;
    end

    assign w_word_done = w_byte_valid && (r_byte_index == LAST_IX);

    always_ff @(posedge clk12) begin
        if (rst) begin
            r_byte_index <= '0;
            r_timeout    <= '0;
            r_word_buf   <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_byte_valid) begin
                r_word_buf   <= w_merged;
                r_timeout    <= '0;
                r_byte_index <= (r_byte_index == LAST_IX) ? '0 : r_byte_index + 1'b1;
            end else if (w_byte_err) begin
                r_frame_err  <= 1'b1;
                r_byte_index <= '0;
                r_timeout    <= '0;
            end else if (r_byte_index != '0) begin
                if (r_timeout == TO_LAST) begin
                    r_byte_index <= '0;
                    r_timeout    <= '0;
                end else begin
                    r_timeout <= r_timeout + 1'b1;
                end
            end
        end
    end

    // An ack in the completion cycle frees the slot, so the new word may replace the old one.
    always_ff @(posedge clk12) begin
        if (rst) begin
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_led        <= 1'b0;
        end else if (w_word_done) begin
            if (!r_word_valid || wif.word_ack) begin
                r_word       <= w_merged;
                r_word_valid <= 1'b1;
                r_led        <= ~r_led;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_word_valid && wif.word_ack) begin
            r_word_valid <= 1'b0;
        end
    end

    assign wif.word       = r_word;
    assign wif.word_valid = r_word_valid;
    assign frame_err      = r_frame_err;
    assign overrun        = r_overrun;
    assign led            = r_led;

endmodule

// File: tb/tb_rx_word.sv
// Self-checking bench for rx_word: table of words plus timeout, framing, glitch, overrun
// and mid-word reset sequences, with a queue of expected words checked as each word lands.
module tb_rx_word;
    import rx_word_pkg::*;

    localparam int CPB = 16;
    localparam int NB  = 4;
    localparam int TO  = 320;
    localparam int W   = 8 * NB;
    localparam int NV  = 10;

    typedef struct {
        logic [7:0]   b [NB];
        logic [W-1:0] exp;
    } vec_t;

    logic      clk12 = 1'b0;
    logic      rst   = 1'b1;
    logic      rx    = 1'b1;
    logic      frame_err;
    logic      overrun;
    logic      led;
    rx_state_e rx_state;

    rx_word_if #(.NUM_BYTES(NB)) wif ();

    rx_word #(
        .CLKS_PER_BIT (CPB),
        .NUM_BYTES    (NB),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk12     (clk12),
        .rst       (rst),
        .rx        (rx),
        .wif       (wif),
        .frame_err (frame_err),
        .overrun   (overrun),
        .led       (led),
        .rx_state  (rx_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk12 = ~clk12;

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int           n_vec    = 0;
    int           n_err    = 0;
    int           n_words  = 0;
    int           n_pushed = 0;
    int           n_fe     = 0;
    int           fe_width = 0;
    int           lat      = 0;
    bit           ack_auto = 1'b0;
    logic         prev_led = 1'b0;
    logic [W-1:0] exp_q[$];
    vec_t         vecs [NV];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        exp_q.push_back(w);
        n_pushed++;
    endtask

    // Consumer: acks one cycle after seeing word_valid when auto mode is on.
    initial begin
        wif.word_ack = 1'b0;
        forever begin
            @(negedge clk12);
            if (ack_auto) wif.word_ack = wif.word_valid;
        end
    end

    // Monitor: a led toggle with word_valid high marks a newly presented word.
    initial begin
        forever begin
            @(negedge clk12);
            if (wif.word_valid === 1'b1 && led !== prev_led) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h want none", wif.word);
                end else begin
                    check("word", wif.word, exp_q.pop_front());
                end
            end
            prev_led = led;
            if (frame_err === 1'b1) begin
                fe_width++;
            end else if (fe_width != 0) begin
                n_fe++;
                check("frame_err_width", W'(fe_width), W'(1));
                fe_width = 0;
            end
        end
    end

    // ---------------- driver tasks (called and returning at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk12);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk12);
        end
        rx = stop;
        repeat (CPB) @(negedge clk12);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk12);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 8 * CPB) begin
            @(negedge clk12);
            t++;
        end
        check({name, "_drain"}, W'(exp_q.size()), W'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic lf;
        int   fe0;

        vecs[0].b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE}; vecs[0].exp = 32'hDEADBEEF;
        vecs[1].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[1].exp = 32'hFFFFFFFF;
        vecs[2].b = '{8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].exp = 32'h00000000;
        vecs[3].b = '{8'h01, 8'h00, 8'h00, 8'h80}; vecs[3].exp = 32'h80000001;
        vecs[4].b = '{8'h55, 8'hAA, 8'h0F, 8'hF0}; vecs[4].exp = 32'hF00FAA55;
        vecs[5].b = '{8'h93, 8'h00, 8'h10, 8'h00}; vecs[5].exp = 32'h00100093;
        for (int i = 6; i < NV; i++) begin
            for (int j = 0; j < NB; j++) vecs[i].b[j] = 8'($urandom_range(0, 255));
            vecs[i].exp = {vecs[i].b[3], vecs[i].b[2], vecs[i].b[1], vecs[i].b[0]};
        end

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk12);
        rst = 1'b0;
        check("rst_word", wif.word, '0);
        check("rst_valid", W'(wif.word_valid), W'(0));
        check("rst_frame_err", W'(frame_err), W'(0));
        check("rst_overrun", W'(overrun), W'(0));
        check("rst_led", W'(led), W'(0));
        check("rst_state", W'(rx_state), W'(RX_IDLE));
        idle(4);

        // Back-to-back bytes, latency measured from the last byte's start edge.
        ack_auto = 1'b1;
        push_word(32'h00100513);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1);
        fork
            send_byte(8'h00, 1'b1);
            begin
                lat = 0;
                while (wif.word_valid !== 1'b1 && lat < 400) begin
                    @(negedge clk12);
                    lat++;
                end
            end
        join
        check("latency_in_window", W'(lat >= (19 * CPB) / 2 && lat <= (19 * CPB) / 2 + 8), W'(1));
        check("led_after_first", W'(led), W'(1));
        drain("first");

        for (int i = 0; i < NV; i++) begin
            push_word(vecs[i].exp);
            for (int j = 0; j < NB; j++) send_byte(vecs[i].b[j], 1'b1);
            drain("table");
        end
        check("no_overrun_yet", W'(overrun), W'(0));

        // Short low glitch must produce nothing.
        lf  = led;
        fe0 = n_fe;
        rx  = 1'b0;
        repeat ((3 * CPB) / 10) @(negedge clk12);
        idle(3 * CPB);
        check("glitch_no_fe", W'(n_fe), W'(fe0));
        check("glitch_led", W'(led), W'(lf));
        check("glitch_valid", W'(wif.word_valid), W'(0));
        check("glitch_state", W'(rx_state), W'(RX_IDLE));

        // Partial word dropped after the idle timeout.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(TO + 10);
        push_word(32'h04030201);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        drain("timeout");

        // Framing error mid-word discards the partial word.
        fe0 = n_fe;
        send_byte(8'h12, 1'b1);
        send_byte(8'h55, 1'b0);
        idle(2 * CPB);
        check("frame_err_count", W'(n_fe), W'(fe0 + 1));
        push_word(32'hDEADBEEF);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        drain("frame");

        // Overrun: second word arrives while the first is unacked.
        ack_auto = 1'b0;
        wif.word_ack = 1'b0;
        idle(2);
        push_word(32'hC0FFEE42);
        send_byte(8'h42, 1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hC0, 1'b1);
        drain("ovr_first");
        lf = led;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        idle(4);
        check("ovr_word_kept", wif.word, 32'hC0FFEE42);
        check("ovr_valid_held", W'(wif.word_valid), W'(1));
        check("ovr_flag", W'(overrun), W'(1));
        check("ovr_led", W'(led), W'(lf));
        wif.word_ack = 1'b1;
        @(negedge clk12);
        wif.word_ack = 1'b0;
        check("ack_clears_valid", W'(wif.word_valid), W'(0));
        check("ovr_sticky", W'(overrun), W'(1));
        check("word_after_ack", wif.word, 32'hC0FFEE42);
        idle(3);
        check("ovr_still_sticky", W'(overrun), W'(1));

        // Reset in the middle of the third byte.
        ack_auto = 1'b1;
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk12);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk12);
        check("mid_byte_state", W'(rx_state), W'(RX_DATA));
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk12);
        rst = 1'b0;
        check("rst2_word", wif.word, '0);
        check("rst2_valid", W'(wif.word_valid), W'(0));
        check("rst2_frame_err", W'(frame_err), W'(0));
        check("rst2_overrun", W'(overrun), W'(0));
        check("rst2_led", W'(led), W'(0));
        idle(2 * CPB);
        push_word(32'h0000006F);
        send_byte(8'h6F, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        drain("after_reset");
        check("led_after_reset_word", W'(led), W'(1));
        idle(8);

        check("pending_words", W'(exp_q.size()), W'(0));
        check("word_count", W'(n_words), W'(n_pushed));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_word.md
Name: rx_word

Overview:
- UART receive path into the core: deserialises 8N1 bytes on `rx` and assembles NUM_BYTES of them into one word, e.g. an instruction from the host.
- Byte 0 received first maps to word[7:0]. This is the same byte ordering the host side uses for register-file dumps.
- Presents the word with a valid/ack handshake.
- Discards partial words on framing error or inter-byte timeout, so the host can resynchronise.

Parameters:
- CLKS_PER_BIT, 104, clk12 cycles per UART bit (12 MHz / 115200).
- NUM_BYTES, 4, bytes per assembled word (range 1..128).
- TIMEOUT_CLKS, 2080, idle cycles after a byte before a partial word is dropped (about 20 bit times).

Ports:
- clk12  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  asynchronous UART line, idle high.
- word  out  8*NUM_BYTES  assembled word; stable while word_valid is high.
- word_valid  out  1  word available; held until acked.
- word_ack  in  1  consumer accepts word; sampled only while word_valid is high.
- frame_err  out  1  one-cycle pulse per byte with bad stop bit.
- overrun  out  1  sticky; a word completed while word_valid was high and unacked.
- led  out  1  toggles on each accepted word.

Behaviour:
- Reset (rst=1 at clk12 edge), overriding all other events:
  - word=0, word_valid=0, frame_err=0, overrun=0, led=0.
  - byte_index=0, timeout counter=0.
  - rx_byte returns to IDLE; synchroniser flops set to 1.
  - Reset mid-byte or mid-word discards all partial data.
- rx_byte sub-module:
  - 2-flop synchroniser on rx; all decisions use the synchronised value.
  - States IDLE, START, DATA, STOP.
  - IDLE: on synced rx=0, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles, then resample.
    - If 0, go to DATA.
    - If 1, treat as a glitch and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first into the shift register.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: byte_valid=1 for one cycle with byte[7:0].
    - If 0: byte_err=1 for one cycle, no byte.
    - Both cases return to IDLE the next cycle, ready for back-to-back bytes.
- Assembler:
  - On byte_valid, write the byte to word_buf[8*byte_index +: 8] and clear the timeout counter.
  - If byte_index==NUM_BYTES-1, the word is complete and byte_index=0; else byte_index+1.
  - Timeout counter runs only while byte_index!=0 and no byte_valid. On reaching TIMEOUT_CLKS: byte_index=0, partial word dropped, counter cleared.
  - On byte_err: frame_err pulses, byte_index=0, partial word dropped, timeout cleared.
- Word completion: in the cycle after the final byte_valid, the output behaves as follows.
  - If word_valid=0: word<=buffer, word_valid<=1, led toggles.
  - If word_valid=1 and word_ack=1 in that same cycle: new word replaces old, word_valid stays 1, led toggles, no overrun.
  - If word_valid=1 and word_ack=0: new word dropped, word unchanged, overrun<=1 (sticky until rst).
- Handshake:
  - word_ack with word_valid=1 and no completing word clears word_valid the next cycle.
  - word_ack while word_valid=0 is ignored.
  - word holds its last value after ack.
- Latency: word_valid rises 1 cycle after the last byte's byte_valid, which is roughly 9.5 bit times after that byte's start edge.
- Widths: byte_index is $clog2(NUM_BYTES) bits, minimum 1; it wraps only via explicit clear. Counters size from their parameters.

Decomposition:
- Shared include/package (alongside the existing baud definitions such as B115200):
  - UART constants: CLKS_PER_BIT for 115200 at 12 MHz.
  - rx_byte state encodings IDLE/START/DATA/STOP.
- One sub-module, uart_rx_byte:
  - Ports: clk12, rst, rx, byte[7:0], byte_valid, byte_err.
  - Parameter CLKS_PER_BIT.
- rx_word instantiates uart_rx_byte and holds the assembler and handshake logic.

Test Plan:
- Send bytes 0x13,0x05,0x10,0x00 back-to-back with ack tied high after valid. Expect word=0x00100513, word_valid high one cycle after the 4th stop sample, and led=1.
- Send one word, hold word_ack=0, then send 0xAA,0xBB,0xCC,0xDD. Expect word unchanged and overrun=1; after ack, word_valid=0 and overrun stays 1.
- Send 0x11,0x22, go idle for TIMEOUT_CLKS+10 cycles, then send 0x01,0x02,0x03,0x04. Expect a single word=0x04030201 and no word containing 0x11.
- Send byte 0x55 with stop bit=0, then a full word 0xDEADBEEF as bytes EF,BE,AD,DE. Expect frame_err one-cycle pulse, byte_index cleared, then word=0xDEADBEEF.
- Send a 0.3-bit low glitch on rx, then idle. Expect no byte_valid, frame_err or word_valid.
- Assert rst for 1 cycle in the middle of byte 3 of a word, then send a full word 0x0000006F. Expect all outputs 0 after reset and the next word=0x0000006F.
